bnn_seq_ctrl: RTL and testbench
===============================

Name: bnn_seq_ctrl

Overview:
Parametrised instruction sequencer for the BNN core. It fetches 16-bit instructions from the instruction SRAM and executes register, compare and branch instructions locally. Core instructions go to the BNN core over a valid/ready handshake, so the core can stall the program. It runs under a start/done handshake and sits between the instruction SRAM and the BNN core datapath decoder.

Parameters:
ADDR_W, 10, PC and instruction-address width (program length 2^ADDR_W)
NREG, 4, number of general registers, 2..8
DATA_W, 16, register width, 9..32

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  begin program at address 0; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until HALT/error completes
done  out  1  one-cycle pulse when execution ends (HALT or error)
err  out  1  sticky illegal-instruction flag; cleared on next accepted start
inst_rd  out  1  instruction SRAM read enable
inst_addr  out  ADDR_W  instruction address (= pc)
inst_rdata  in  16  instruction data, valid the cycle after inst_rd
core_valid  out  1  core instruction presented
core_ready  in  1  core accepts presented instruction
core_op  out  5  core opcode (inst[15:11])
core_arg  out  11  core argument (inst[10:0])

Behaviour:
- Reset (async, any state): state=IDLE, pc=0, all regs=0, flag=0.
- Reset outputs: busy=0, done=0, err=0, inst_rd=0, core_valid=0, core_op=0, core_arg=0. core_valid falls immediately on reset.
- States:
  - IDLE: on start, clear pc, registers, flag and err, then go to FETCH.
  - FETCH: inst_rd=1, inst_addr=pc, then go to EXEC.
  - EXEC: latch inst_rdata into ir and decode it.
  - ISSUE: hold core_valid=1.
  - FIN: done=1 for one cycle, then go to IDLE.
- Instruction encoding: op = ir[15:11], reg index = ir[10:8], imm8 = ir[7:0].
- Internal instructions (EXEC then FETCH; 2 cycles each):
  - 00000 NOP: pc+1.
  - 00001 LDL: r[idx][7:0] <= imm8, upper bits kept.
  - 01101 LDH: r[idx][15:8] <= imm8, other bits kept.
  - 00011 ADDI: r[idx] <= r[idx] + sign-extended imm8, modulo 2^DATA_W.
  - 00100 CMP: flag <= (r[idx] > zero-extended imm8), unsigned compare.
  - 00101 JMPB: if flag, pc <= pc - ir[10:0] modulo 2^ADDR_W; else pc+1. flag is unchanged.
  - 11111 HALT: go to FIN; pc is unchanged.
- Core instructions are 00010 and 00110..01100. EXEC goes to ISSUE with core_op/core_arg taken from ir.
  - core_op, core_arg and core_valid stay stable until core_valid && core_ready.
  - On handshake: pc+1, core_valid=0 next cycle, go to FETCH. Minimum 3 cycles per core instruction.
- Illegal instructions set err and go to FIN; no register or pc change. Illegal means:
  - opcode 01110..11110;
  - reg index >= NREG on LDL, LDH, ADDI or CMP.
- pc+1 wraps modulo 2^ADDR_W.
- start is ignored while busy.
- busy deasserts in the same cycle done pulses.

Test Plan:
- Loop program (NREG=4, core_ready=1): 0:0x0803 (LDL r0,3), 1:0x3000 (core op 00110), 2:0x18FF (ADDI r0,-1), 3:0x2000 (CMP r0,0), 4:0x2803 (JMPB 3), 5:0xF800 (HALT), then pulse start -> exactly 3 core handshakes with core_op=00110, r0 ends at 0, one done pulse, err=0.
- Stall: single core op 0x3A55 with core_ready low for 5 cycles -> core_valid held high 5+ cycles, core_op=00111, core_arg=0x255 stable, inst_rd=0 throughout, pc advances only after ready.
- Arithmetic: LDH r1,0xFF; LDL r1,0xFF; ADDI r1,+1 -> r1=0x0000 (wrap); CMP r1,0 -> flag=0, so JMPB falls through.
- Illegal: opcode 01110 at address 2 -> err=1, done pulse, busy=0, regs unchanged. Next start clears err.
- Reg range (NREG=4): 0x0D12 (LDL r5) -> err=1, no write.
- Reset mid-ISSUE with core_ready=0 -> core_valid, busy and err all 0 immediately; start afterwards runs from address 0.

Source files
------------

// File: rtl/bnn_seq_ctrl_if.sv
//============================================================================
// Module  : bnn_seq_ctrl_if
// Brief   : Start/done, instruction SRAM and core-issue signals of bnn_seq_ctrl
// Revision: 1.0
//============================================================================
`default_nettype none

interface bnn_seq_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic              inst_rd;
  logic [ADDR_W-1:0] inst_addr;
  logic [15:0]       inst_rdata;
  logic              core_valid;
  logic              core_ready;
  logic [4:0]        core_op;
  logic [10:0]       core_arg;

  modport master (
    input  start, inst_rdata, core_ready,
    output busy, done, err, inst_rd, inst_addr, core_valid, core_op, core_arg
  );

  modport slave (
    output start, inst_rdata, core_ready,
    input  busy, done, err, inst_rd, inst_addr, core_valid, core_op, core_arg
  );
endinterface

`default_nettype wire

// File: rtl/bnn_seq_ctrl.sv
//============================================================================
// Module  : bnn_seq_ctrl
// Brief   : BNN instruction sequencer; runs register/branch ops locally and
//           hands core ops to the datapath over valid/ready
// Revision: 1.0
//============================================================================
`default_nettype none

module bnn_seq_ctrl #(
  parameter int ADDR_W = 10,
  parameter int NREG   = 4,
  parameter int DATA_W = 16
) (
  input  wire logic       clk,
  input  wire logic       rst,
  bnn_seq_ctrl_if.master  bus
);

  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [DATA_W-1:0] C_HI_MASK = DATA_W'(32'h0000_FF00);

  localparam logic [4:0] C_OP_NOP  = 5'b00000;
  localparam logic [4:0] C_OP_LDL  = 5'b00001;
  localparam logic [4:0] C_OP_ADDI = 5'b00011;
  localparam logic [4:0] C_OP_CMP  = 5'b00100;
  localparam logic [4:0] C_OP_JMPB = 5'b00101;
  localparam logic [4:0] C_OP_LDH  = 5'b01101;
  localparam logic [4:0] C_OP_HALT = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_ISSUE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic              r_flag;
  logic              r_err;
  logic [DATA_W-1:0] r_regs [NREG];

  logic [4:0]        w_op;
  logic [2:0]        w_idx;
  logic [7:0]        w_imm;
  logic [IDX_W-1:0]  w_sel;
  logic [DATA_W-1:0] w_cur;
  logic              w_is_core;
  logic              w_reg_op;
  logic              w_known;
  logic              w_illegal;

  // Decode works on the SRAM word directly; ir only keeps it for the issue phase.
  assign w_op  = bus.inst_rdata[15:11];
  assign w_idx = bus.inst_rdata[10:8];
  assign w_imm = bus.inst_rdata[7:0];
  assign w_sel = w_idx[IDX_W-1:0];
  assign w_cur = r_regs[w_sel];

  assign w_is_core = (w_op == 5'b00010) || ((w_op >= 5'b00110) && (w_op <= 5'b01100));
  assign w_reg_op  = (w_op == C_OP_LDL) || (w_op == C_OP_LDH) ||
                     (w_op == C_OP_ADDI) || (w_op == C_OP_CMP);
  assign w_known   = w_is_core || w_reg_op || (w_op == C_OP_NOP) ||
                     (w_op == C_OP_JMPB) || (w_op == C_OP_HALT);
  assign w_illegal = !w_known || (w_reg_op && (32'(w_idx) >= 32'(NREG)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.inst_rd    = 1'b0;
    bus.core_valid = 1'b0;
    bus.core_op    = 5'd0;
    bus.core_arg   = 11'd0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_FETCH;
      end
      S_FETCH: begin
        bus.busy    = 1'b1;
        bus.inst_rd = 1'b1;
        w_next      = S_EXEC;
      end
      S_EXEC: begin
        bus.busy = 1'b1;
        if (w_illegal || (w_op == C_OP_HALT)) w_next = S_FIN;
        else if (w_is_core)                   w_next = S_ISSUE;
        else                                  w_next = S_FETCH;
      end
      S_ISSUE: begin
        bus.busy       = 1'b1;
        bus.core_valid = 1'b1;
        bus.core_op    = r_ir[15:11];
        bus.core_arg   = r_ir[10:0];
        if (bus.core_ready) w_next = S_FETCH;
      end
      S_FIN: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.inst_addr = r_pc;
  assign bus.err       = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= '0;
      r_ir   <= '0;
      r_flag <= 1'b0;
      r_err  <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_pc   <= '0;
            r_flag <= 1'b0;
            r_err  <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
          end
        end
        S_EXEC: begin
          r_ir <= bus.inst_rdata;
          if (w_illegal) begin
            r_err <= 1'b1;
          end else begin
            case (w_op)
              C_OP_NOP: r_pc <= r_pc + ADDR_W'(1);
              C_OP_LDL: begin
                r_regs[w_sel] <= {w_cur[DATA_W-1:8], w_imm};
                r_pc          <= r_pc + ADDR_W'(1);
              end
              C_OP_LDH: begin
                r_regs[w_sel] <= (w_cur & ~C_HI_MASK) | (DATA_W'({w_imm, 8'h00}) & C_HI_MASK);
                r_pc          <= r_pc + ADDR_W'(1);
              end
              C_OP_ADDI: begin
                r_regs[w_sel] <= w_cur + {{(DATA_W-8){w_imm[7]}}, w_imm};
                r_pc          <= r_pc + ADDR_W'(1);
              end
              C_OP_CMP: begin
                r_flag <= (w_cur > {{(DATA_W-8){1'b0}}, w_imm});
                r_pc   <= r_pc + ADDR_W'(1);
              end
              C_OP_JMPB: begin
                if (r_flag) r_pc <= r_pc - ADDR_W'(bus.inst_rdata[10:0]);
                else        r_pc <= r_pc + ADDR_W'(1);
              end
              default: ; // HALT and core ops leave pc alone here
            endcase
          end
        end
        S_ISSUE: begin
          if (bus.core_ready) r_pc <= r_pc + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bnn_seq_ctrl.sv
//============================================================================
// Module  : tb_bnn_seq_ctrl
// Brief   : Scoreboard bench for bnn_seq_ctrl with directed programs
// Revision: 1.0
//============================================================================
`default_nettype none

module tb_bnn_seq_ctrl;

  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bnn_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  bnn_seq_ctrl #(.ADDR_W(ADDR_W), .NREG(4), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [1024];
  always @(posedge clk) if (bus.inst_rd) bus.inst_rdata <= mem[bus.inst_addr];

  typedef struct packed { logic [4:0] op; logic [10:0] arg; } core_t;
  core_t exp_core[$];
  logic  exp_err[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake and every done pulse is matched against the queues.
  always @(negedge clk) begin
    core_t e;
    logic  ee;
    if (!rst && bus.core_valid && bus.core_ready) begin
      if (exp_core.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL core_unexpected: got op %0h arg %0h expected none", bus.core_op, bus.core_arg);
      end else begin
        e = exp_core.pop_front();
        check("core_op", 32'(bus.core_op), 32'(e.op));
        check("core_arg", 32'(bus.core_arg), 32'(e.arg));
      end
    end
    if (!rst && bus.done) begin
      check("busy_at_done", 32'(bus.busy), 32'd0);
      if (exp_err.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL done_unexpected: got done expected none");
      end else begin
        ee = exp_err.pop_front();
        check("err_at_done", 32'(bus.err), 32'(ee));
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'hF800;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1 bus.core_ready = v;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.done) begin seen = 1'b1; break; end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.core_valid) begin seen = 1'b1; break; end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.core_ready = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_inst_rd", 32'(bus.inst_rd), 32'd0);
    check("rst_core_valid", 32'(bus.core_valid), 32'd0);
    check("rst_core_op_arg", {16'd0, bus.core_op, bus.core_arg}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Loop: r0 counts 3..0, one core op per pass
    clear_mem();
    mem[0] = 16'h0803; mem[1] = 16'h3000; mem[2] = 16'h18FF;
    mem[3] = 16'h2000; mem[4] = 16'h2803; mem[5] = 16'hF800;
    set_ready(1'b1);
    repeat (3) exp_core.push_back('{5'b00110, 11'h000});
    exp_err.push_back(1'b0);
    pulse_start();
    @(negedge clk);
    check("loop_busy", 32'(bus.busy), 32'd1);
    wait_done("loop_done", 200);
    check("loop_r0", 32'(dut.r_regs[0]), 32'd0);

    // Arithmetic wrap: r1 = 0xFFFF + 1 = 0, so JMPB must fall through
    clear_mem();
    mem[0] = 16'h69FF; mem[1] = 16'h09FF; mem[2] = 16'h1901;
    mem[3] = 16'h2100; mem[4] = 16'h2804; mem[5] = 16'h1001; mem[6] = 16'hF800;
    exp_core.push_back('{5'b00010, 11'h001});
    exp_err.push_back(1'b0);
    pulse_start();
    wait_done("arith_done", 200);
    check("arith_r1", 32'(dut.r_regs[1]), 32'd0);
    check("arith_flag", 32'(dut.r_flag), 32'd0);

    // Stall: core_ready low for 5 cycles
    clear_mem();
    mem[0] = 16'h3A55; mem[1] = 16'hF800;
    set_ready(1'b0);
    pulse_start();
    wait_valid("stall_valid_seen", 10);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(bus.core_valid), 32'd1);
      check("stall_op", 32'(bus.core_op), 32'h07);
      check("stall_arg", 32'(bus.core_arg), 32'h255);
      check("stall_inst_rd", 32'(bus.inst_rd), 32'd0);
      check("stall_pc", 32'(bus.inst_addr), 32'd0);
      @(negedge clk);
    end
    exp_core.push_back('{5'b00111, 11'h255});
    exp_err.push_back(1'b0);
    set_ready(1'b1);
    @(negedge clk);
    @(negedge clk);
    check("stall_pc_after", 32'(bus.inst_addr), 32'd1);
    check("stall_fetch", 32'(bus.inst_rd), 32'd1);
    wait_done("stall_done", 50);

    // Illegal opcode at address 2
    clear_mem();
    mem[0] = 16'h0A05; mem[1] = 16'h0000; mem[2] = 16'h7000;
    exp_err.push_back(1'b1);
    pulse_start();
    wait_done("illegal_done", 50);
    @(negedge clk);
    check("illegal_err_sticky", 32'(bus.err), 32'd1);
    check("illegal_busy", 32'(bus.busy), 32'd0);
    check("illegal_r2", 32'(dut.r_regs[2]), 32'h0005);
    check("illegal_pc", 32'(bus.inst_addr), 32'd2);

    // Register index out of range: LDL r5 with NREG=4
    clear_mem();
    mem[0] = 16'h0D12;
    exp_err.push_back(1'b1);
    pulse_start();
    @(negedge clk);
    check("restart_err_clear", 32'(bus.err), 32'd0);
    wait_done("range_done", 50);
    check("range_r1", 32'(dut.r_regs[1]), 32'd0);
    check("range_err", 32'(bus.err), 32'd1);

    // Asynchronous reset while a core op is stalled
    clear_mem();
    mem[0] = 16'h3000;
    set_ready(1'b0);
    pulse_start();
    wait_valid("rstmid_valid_seen", 10);
    #2 rst = 1'b1;
    #1;
    check("rstmid_valid", 32'(bus.core_valid), 32'd0);
    check("rstmid_busy", 32'(bus.busy), 32'd0);
    check("rstmid_err", 32'(bus.err), 32'd0);
    check("rstmid_op", 32'(bus.core_op), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    exp_core.push_back('{5'b00110, 11'h000});
    exp_err.push_back(1'b0);
    set_ready(1'b1);
    pulse_start();
    @(negedge clk);
    check("rstmid_fetch_addr", 32'(bus.inst_addr), 32'd0);
    check("rstmid_fetch_rd", 32'(bus.inst_rd), 32'd1);
    wait_done("rstmid_done", 50);

    repeat (3) @(negedge clk);
    check("core_queue_empty", 32'(exp_core.size()), 32'd0);
    check("done_queue_empty", 32'(exp_err.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
